// File: rtl/mdu_hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes and the
// control FSM state encoding.
package mdu_hilo_pkg;

  // funct field codes handled (or observed) by the MDU
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mdu_divider.sv
// Restoring shift-subtract divider on unsigned magnitudes. load_i captures
// the operands, each step_i retires one quotient bit (MSB first). A zero
// divisor is flagged and the quotient forced to all ones.
module mdu_divider
  import mdu_hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            dz_o
);

  logic [XLEN-1:0] rem_q, quot_q, dvs_q;
  logic            dz_q;
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Shift the next dividend bit into the remainder and trial-subtract.
  // When ge holds, partial - divisor < divisor, so the low XLEN bits are exact.
  always_comb begin
    partial = {rem_q, quot_q[XLEN-1]};
    ge      = (partial >= {1'b0, dvs_q});
    diff    = partial[XLEN-1:0] - dvs_q;
  end

  // Operand capture and one restoring step per step_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      dz_q   <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
      dvs_q  <= divisor_i;
      dz_q   <= (divisor_i == '0);
    end else if (step_i) begin
      quot_q <= {quot_q[XLEN-2:0], ge};
      rem_q  <= ge ? diff : partial[XLEN-1:0];
    end
  end

  // With a zero divisor every trial succeeds, so the dividend shifts
  // straight through into the remainder; only the quotient needs forcing.
  assign quot_o = dz_q ? '1 : quot_q;
  assign rem_o  = rem_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers (EX stage).
// MULT/MULTU/DIV/DIVU take 33 cycles; MTHI/MTLO write in one edge.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply, HI/LO
// written one edge after acceptance. Without it no multiplier is inferred.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              mul_q, mul_d;    // op in flight is a multiply
  logic              qneg_q, qneg_d;  // product / quotient negative
  logic              rneg_q, rneg_d;  // remainder takes dividend's sign

  logic              is_mul, is_div, is_sgn, rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem;
  logic              dz;

  // Decode and operand magnitudes for the signed forms
  always_comb begin
    is_mul = (funct == F_MULT) || (funct == F_MULTU);
    is_div = (funct == F_DIV)  || (funct == F_DIVU);
    is_sgn = (funct == F_MULT) || (funct == F_DIV);
    rs_neg = is_sgn & rs_data[XLEN-1];
    rt_neg = is_sgn & rt_data[XLEN-1];
    rs_mag = rs_neg ? -rs_data : rs_data;
    rt_mag = rt_neg ? -rt_data : rt_data;
  end

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (start && (state_q == S_IDLE) && is_div),
    .step_i     ((state_q == S_CALC) && !mul_q),
    .dividend_i (rs_mag),
    .divisor_i  (rt_mag),
    .quot_o     (quot),
    .rem_o      (rem),
    .dz_o       (dz)
  );

  // Shift-add step: add the multiplicand into the upper half when the
  // multiplier LSB (acc[0]) is set, then shift the whole accumulator right.
  always_comb begin
    psum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    prod_fix = qneg_q ? -acc_q : acc_q;
  end

  // Control FSM and next-state datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mul_d   = mul_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            mul_d   = is_mul;
            qneg_d  = rs_neg ^ rt_neg;
            rneg_d  = rs_neg;
            cnt_d   = '0;
            busy_d  = 1'b1;
            mcand_d = rs_mag;
            acc_d   = {{XLEN{1'b0}}, rt_mag};
            state_d = S_CALC;
`ifdef MDU_FAST_MUL_EN
            // Whole magnitude product now; FIX applies the sign next edge
            if (is_mul) begin
              acc_d   = {{XLEN{1'b0}}, rs_mag} * {{XLEN{1'b0}}, rt_mag};
              state_d = S_FIX;
            end
`endif
          end else if (funct == F_MTHI) begin
            hi_d = rs_data;
          end else if (funct == F_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_CALC: begin
        if (mul_q) acc_d = {psum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (mul_q) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else begin
          // Divide-by-zero quotient stays all ones; remainder sign
          // restore returns the raw dividend in that case.
          lo_d = (qneg_q && !dz) ? -quot : quot;
          hi_d = rneg_q ? -rem : rem;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mul_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mul_q   <= mul_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo (default build, iterative multiply).
module tb_mdu_hilo;

  logic        CLK = 1'b0;
  logic        RST, start;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_hilo dut (
    .CLK(CLK), .RST(RST), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue a MULT/DIV-class op, check latency, result and post-op flags
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge CLK);
    start = 1'b1; funct = f; rs_data = a; rt_data = b;
    @(posedge CLK); #1;
    start = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd33);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk({tag, ".done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt;
    RST = 1'b1; start = 1'b0; funct = '0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    RST = 1'b0;

    // Idle MTHI then MTLO on consecutive edges
    start = 1'b1; funct = 6'h11; rs_data = 32'h1234;
    @(posedge CLK); #1;
    chk("mthi.busy", 32'(busy), 32'd0);
    @(negedge CLK);
    funct = 6'h13; rs_data = 32'h5678;
    @(posedge CLK); #1;
    chk("mtlo.busy", 32'(busy), 32'd0);
    chk("mtlo.done", 32'(done), 32'd0);
    @(negedge CLK);
    start = 1'b0;
    chk("mt.hi", hi, 32'h1234);
    chk("mt.lo", lo, 32'h5678);

    run_op("mult",  6'h18, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // DIV in flight: MTHI ignored while busy, then reset aborts the op
    @(negedge CLK);
    start = 1'b1; funct = 6'h1A; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge CLK); #1;                 // E0
    start = 1'b0;
    repeat (4) @(posedge CLK);          // E4
    @(negedge CLK);
    start = 1'b1; funct = 6'h11; rs_data = 32'h1234;
    @(posedge CLK); #1;                 // E5
    start = 1'b0;
    chk("abort.mthi_ignored", hi, 32'hFFFFFFFE);
    chk("abort.busy_mid", 32'(busy), 32'd1);
    repeat (4) @(posedge CLK);          // E9
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;                 // E10 with reset
    RST = 1'b0;
    chk("abort.hi", hi, 32'h0);
    chk("abort.lo", lo, 32'h0);
    chk("abort.busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (done) dcnt++;
    end
    chk("abort.no_done", 32'(dcnt), 32'd0);
    chk("abort.hi_hold", hi, 32'h0);

    run_op("div",      6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_dz",  6'h1B, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
    run_op("div_dz",   6'h1A, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",  6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_big", 6'h1B, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF);

    // Start at the done edge is ignored; the next edge (done high) accepts
    @(negedge CLK);
    start = 1'b1; funct = 6'h19; rs_data = 32'd3; rt_data = 32'd5;
    @(posedge CLK); #1;                 // E0
    start = 1'b0;
    repeat (32) @(posedge CLK);         // E32
    @(negedge CLK);
    start = 1'b1; funct = 6'h13; rs_data = 32'hAAAA;
    @(posedge CLK); #1;                 // E33
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.lo_e33", lo, 32'd15);
    chk("b2b.hi_e33", hi, 32'd0);
    @(posedge CLK); #1;                 // E34
    start = 1'b0;
    chk("b2b.lo_e34", lo, 32'hAAAA);
    chk("b2b.done_e34", 32'(done), 32'd0);
    chk("b2b.busy_e34", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
